// File: rtl/vfifo_sync_fwft_ctrl_if.sv
// rtl/vfifo_sync_fwft_ctrl_if.sv - write, RAM and FWFT read signals of the FIFO controller
interface vfifo_sync_fwft_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] wr_dat;
    logic                  wr_en;
    logic                  full;
    logic [DATA_WIDTH-1:0] ram_d_a;
    logic [ADDR_WIDTH-1:0] ram_adr_a;
    logic                  ram_we_a;
    logic [ADDR_WIDTH-1:0] ram_adr_b;
    logic [DATA_WIDTH-1:0] ram_q_b;
    logic [DATA_WIDTH-1:0] rd_dat;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [ADDR_WIDTH+1:0] count;

    modport slave (
        input  wr_dat, wr_en, ram_q_b, rd_ready,
        output full, ram_d_a, ram_adr_a, ram_we_a, ram_adr_b, rd_dat, rd_valid, count
    );

    modport master (
        output wr_dat, wr_en, ram_q_b, rd_ready,
        input  full, ram_d_a, ram_adr_a, ram_we_a, ram_adr_b, rd_dat, rd_valid, count
    );
endinterface

// File: rtl/vfifo_sync_fwft_ctrl.sv
// rtl/vfifo_sync_fwft_ctrl.sv - single-clock FIFO controller with FWFT read over a registered-read RAM
module vfifo_sync_fwft_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input logic                  clk,
    input logic                  rst,
    vfifo_sync_fwft_ctrl_if.slave bus
);
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   mem_cnt, mem_cnt_nxt;
    logic                  inflight;
    logic [1:0]            obuf_cnt, obuf_cnt_nxt;
    logic [DATA_WIDTH-1:0] obuf0, obuf1, obuf0_nxt, obuf1_nxt;
    logic                  full, wr_acc, pop, issue;
    logic [2:0]            occ_after_pop;

    // full looks only at RAM occupancy so a same-cycle read cannot free the slot being read
    assign full          = (mem_cnt == DEPTH);
    assign wr_acc        = bus.wr_en & ~full;
    assign pop           = (obuf_cnt != 2'd0) & bus.rd_ready;
    assign occ_after_pop = {1'b0, obuf_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign issue         = (mem_cnt != '0) & (occ_after_pop < 3'd2);

    always_comb begin
        mem_cnt_nxt = mem_cnt;
        if (wr_acc && !issue) begin
            mem_cnt_nxt = mem_cnt + (ADDR_WIDTH+1)'(1);
        end else if (!wr_acc && issue) begin
            mem_cnt_nxt = mem_cnt - (ADDR_WIDTH+1)'(1);
        end
    end

    // Pop shifts entry 1 down first; the RAM word then lands in the first free slot.
    always_comb begin
        obuf0_nxt    = obuf0;
        obuf1_nxt    = obuf1;
        obuf_cnt_nxt = obuf_cnt;
        if (pop) begin
            obuf0_nxt    = obuf1;
            obuf_cnt_nxt = obuf_cnt - 2'd1;
        end
        if (inflight) begin
            if (obuf_cnt_nxt == 2'd0) begin
                obuf0_nxt = bus.ram_q_b;
            end else begin
                obuf1_nxt = bus.ram_q_b;
            end
            obuf_cnt_nxt = obuf_cnt_nxt + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem_cnt  <= '0;
            inflight <= 1'b0;
            obuf_cnt <= 2'd0;
            obuf0    <= '0;
            obuf1    <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            mem_cnt  <= mem_cnt_nxt;
            inflight <= issue;
            obuf_cnt <= obuf_cnt_nxt;
            obuf0    <= obuf0_nxt;
            obuf1    <= obuf1_nxt;
        end
    end

    assign bus.full      = full;
    assign bus.ram_d_a   = bus.wr_dat;
    assign bus.ram_adr_a = wr_ptr;
    assign bus.ram_we_a  = wr_acc;
    assign bus.ram_adr_b = rd_ptr;
    assign bus.rd_dat    = obuf0;
    assign bus.rd_valid  = (obuf_cnt != 2'd0);
    assign bus.count     = {1'b0, mem_cnt} + (ADDR_WIDTH+2)'(inflight) + (ADDR_WIDTH+2)'(obuf_cnt);
endmodule
